// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute controller.
// Op codes, FSM states, flag bit positions and the one-hot op decoder.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_MUL,
        OP_SUB,
        OP_AND,
        OP_XOR,
        OP_ILL
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    // Bit positions inside the {N,V,C,Z} flag vector
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    // Button codes as seen on op_onehot = {X,N,S,M}
    localparam logic [3:0] CODE_ADD = 4'b0000;
    localparam logic [3:0] CODE_MUL = 4'b0001;
    localparam logic [3:0] CODE_SUB = 4'b0010;
    localparam logic [3:0] CODE_AND = 4'b0100;
    localparam logic [3:0] CODE_XOR = 4'b1000;

    // Map a button pattern to an operation; anything unexpected is illegal
    function automatic op_e op_decode(input logic [3:0] code);
        op_e op;
        case (code)
            CODE_ADD: op = OP_ADD;
            CODE_MUL: op = OP_MUL;
            CODE_SUB: op = OP_SUB;
            CODE_AND: op = OP_AND;
            CODE_XOR: op = OP_XOR;
            default:  op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_controller_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// o_product is the accumulator value that the current step produces, so the
// caller can capture the full product on the same edge as the final step.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // Add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    // Load operands, then shift one multiplier bit per step
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= (2*WIDTH)'(i_a);
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_product = w_acc_nxt;
    assign o_last    = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_exec_controller.sv
// ALU execute controller: captures operands, runs add/sub/and/xor in one
// cycle and multiply over WIDTH cycles, and registers result plus {N,V,C,Z}.
// Optional macro ALU_EXEC_ACC_EN adds acc_mode, which takes operand B from
// the low half of the previous result for chained operations.
module alu_exec_controller
    import alu_exec_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SENS_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     spi_data,
    input  logic                 spi_valid,
    input  logic [SENS_W-1:0]    sensor_b,
    input  logic [3:0]           op_onehot,
    input  logic                 start,
`ifdef ALU_EXEC_ACC_EN
    input  logic                 acc_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 op_error,
    output logic [WIDTH-1:0]     operand_a,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags
);

    state_e               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_result;
    logic [3:0]           r_flags;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_op_error;

    op_e                  w_op;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_alu_lo;
    logic                 w_alu_c;
    logic                 w_alu_v;
    logic [3:0]           w_alu_flags;
    logic [3:0]           w_mul_flags;
    logic                 w_mul_load;
    logic                 w_mul_step;
    logic [2*WIDTH-1:0]   w_mul_product;
    logic                 w_mul_last;

    assign w_op = op_decode(op_onehot);

`ifdef ALU_EXEC_ACC_EN
    assign w_b = acc_mode ? r_result[WIDTH-1:0] : WIDTH'(sensor_b);
`else
    assign w_b = WIDTH'(sensor_b);
`endif

    // Operand A register follows every SPI strobe, even mid-operation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a <= '0;
        end else if (spi_valid) begin
            r_a <= spi_data;
        end
    end

    // Single-cycle ALU path and its flags, evaluated on the live operands
    always_comb begin
        w_sum    = {1'b0, r_a} + {1'b0, w_b};
        w_diff   = {1'b0, r_a} - {1'b0, w_b};
        w_alu_lo = '0;
        w_alu_c  = 1'b0;
        w_alu_v  = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu_lo = w_sum[WIDTH-1:0];
                w_alu_c  = w_sum[WIDTH];
                w_alu_v  = (r_a[WIDTH-1] == w_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the difference is the borrow (A < B)
                w_alu_lo = w_diff[WIDTH-1:0];
                w_alu_c  = w_diff[WIDTH];
                w_alu_v  = (r_a[WIDTH-1] != w_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND:  w_alu_lo = r_a & w_b;
            OP_XOR:  w_alu_lo = r_a ^ w_b;
            default: w_alu_lo = '0;
        endcase
        w_alu_flags        = '0;
        w_alu_flags[FLG_Z] = (w_alu_lo == '0);
        w_alu_flags[FLG_C] = w_alu_c;
        w_alu_flags[FLG_V] = w_alu_v;
        w_alu_flags[FLG_N] = w_alu_lo[WIDTH-1];
    end

    // Multiply flags: carry means the product spilled into the upper half
    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_mul_product == '0);
        w_mul_flags[FLG_C] = (w_mul_product[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLG_V] = 1'b0;
        w_mul_flags[FLG_N] = w_mul_product[2*WIDTH-1];
    end

    assign w_mul_load = (r_state == S_IDLE) && start && (w_op == OP_MUL);
    assign w_mul_step = (r_state == S_MUL);

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_a       (r_a),
        .i_b       (w_b),
        .o_product (w_mul_product),
        .o_last    (w_mul_last)
    );

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_flags    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_op_error <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_op_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_op == OP_ILL) begin
                            r_op_error <= 1'b1;
                        end else if (w_op == OP_MUL) begin
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else begin
                            r_result <= (2*WIDTH)'(w_alu_lo);
                            r_flags  <= w_alu_flags;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        r_result <= w_mul_product;
                        r_flags  <= w_mul_flags;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign op_error  = r_op_error;
    assign operand_a = r_a;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_exec_controller.sv
// Directed bench for alu_exec_controller at WIDTH=4, SENS_W=2.
module tb_alu_exec_controller;

    localparam int W  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [W-1:0]   spi_data;
    logic           spi_valid;
    logic [SW-1:0]  sensor_b;
    logic [3:0]     op_onehot;
    logic           start;
`ifdef ALU_EXEC_ACC_EN
    logic           acc_mode;
`endif
    logic           busy;
    logic           done;
    logic           op_error;
    logic [W-1:0]   operand_a;
    logic [2*W-1:0] result;
    logic [3:0]     flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_controller #(
        .WIDTH  (W),
        .SENS_W (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_data  (spi_data),
        .spi_valid (spi_valid),
        .sensor_b  (sensor_b),
        .op_onehot (op_onehot),
        .start     (start),
`ifdef ALU_EXEC_ACC_EN
        .acc_mode  (acc_mode),
`endif
        .busy      (busy),
        .done      (done),
        .op_error  (op_error),
        .operand_a (operand_a),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [SW-1:0]  b;
        logic [3:0]     op;
        logic [2*W-1:0] res;
        logic [3:0]     flg;   // {N,V,C,Z}
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_a(input logic [W-1:0] a);
        spi_data  = a;
        spi_valid = 1'b1;
        tick();
        spi_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{a: 4'h7, b: 2'd2, op: 4'b0000, res: 8'h09, flg: 4'b1100};
        vecs[1] = '{a: 4'h3, b: 2'd3, op: 4'b0010, res: 8'h00, flg: 4'b0001};
        vecs[2] = '{a: 4'h1, b: 2'd3, op: 4'b0010, res: 8'h0E, flg: 4'b1010};
        vecs[3] = '{a: 4'hF, b: 2'd1, op: 4'b0000, res: 8'h00, flg: 4'b0011};
        vecs[4] = '{a: 4'h8, b: 2'd1, op: 4'b0010, res: 8'h07, flg: 4'b0100};
        vecs[5] = '{a: 4'hE, b: 2'd3, op: 4'b0100, res: 8'h02, flg: 4'b0000};
        vecs[6] = '{a: 4'hC, b: 2'd3, op: 4'b1000, res: 8'h0F, flg: 4'b1000};
        vecs[7] = '{a: 4'hC, b: 2'd3, op: 4'b0100, res: 8'h00, flg: 4'b0001};
        vecs[8] = '{a: 4'hF, b: 2'd3, op: 4'b0000, res: 8'h02, flg: 4'b0010};

        // Reset held two cycles with noisy inputs
        reset_n   = 1'b0;
        spi_data  = 4'h5;
        spi_valid = 1'b1;
        sensor_b  = 2'd3;
        op_onehot = 4'b0000;
        start     = 1'b1;
`ifdef ALU_EXEC_ACC_EN
        acc_mode  = 1'b0;
`endif
        tick();
        tick();
        check("rst_a", operand_a, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", op_error, 0);
        spi_valid = 1'b0;
        start     = 1'b0;
        reset_n   = 1'b1;
        tick();

        // Single-cycle operations from the table
        for (int i = 0; i < 9; i++) begin
            load_a(vecs[i].a);
            sensor_b  = vecs[i].b;
            op_onehot = vecs[i].op;
            start     = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("vec%0d_done", i), done, 1);
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].flg);
            tick();
            check($sformatf("vec%0d_done_drop", i), done, 0);
        end

        // Multiply 15*3 with an ignored start and an SPI update mid-flight
        load_a(4'hF);
        sensor_b  = 2'd3;
        op_onehot = 4'b0001;
        start     = 1'b1;
        tick();
        check("mul_busy0", busy, 1);
        check("mul_done0", done, 0);
        op_onehot = 4'b0000;
        spi_data  = 4'h1;
        spi_valid = 1'b1;
        tick();
        start     = 1'b0;
        spi_valid = 1'b0;
        check("mul_busy1", busy, 1);
        tick();
        tick();
        check("mul_busy3", busy, 1);
        check("mul_done3", done, 0);
        tick();
        check("mul_done4", done, 1);
        check("mul_busy4", busy, 0);
        check("mul_result", result, 8'h2D);
        check("mul_flags", flags, 4'b0010);
        check("mul_a_updated", operand_a, 4'h1);
        tick();
        check("mul_done_drop", done, 0);
        tick();
        check("mul_no_queued_done", done, 0);

        // Illegal op code leaves result and flags alone
        op_onehot = 4'b0011;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("ill_err", op_error, 1);
        check("ill_done", done, 0);
        check("ill_result", result, 8'h2D);
        check("ill_flags", flags, 4'b0010);
        tick();
        check("ill_err_drop", op_error, 0);
        check("ill_busy", busy, 0);

        // Reset in the middle of a multiply
        op_onehot = 4'b0001;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", flags, 0);
        check("midrst_a", operand_a, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("midrst_no_done%0d", k), done, 0);
        end

        // Fresh multiply after reset: 3*3
        load_a(4'h3);
        sensor_b  = 2'd3;
        op_onehot = 4'b0001;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mul2_done", done, 1);
        check("mul2_result", result, 8'h09);
        check("mul2_flags", flags, 4'b0000);
        tick();

`ifdef ALU_EXEC_ACC_EN
        // Chained add: 2+1, then 4 + previous result
        load_a(4'h2);
        sensor_b  = 2'd1;
        op_onehot = 4'b0000;
        acc_mode  = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("acc1_result", result, 8'h03);
        tick();
        load_a(4'h4);
        sensor_b = 2'd0;
        acc_mode = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        acc_mode = 1'b0;
        check("acc2_result", result, 8'h07);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
